// File: rtl/equiv_pkg.sv
// Shared types for the equivalence sweep checker family.
package equiv_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/equiv_sweep_checker_settle_timer.sv
// Load/decrement counter with zero flag; holds each swept vector for a fixed number of cycles.
module settle_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/equiv_sweep_checker.sv
// Exhaustive input sweep comparing two circuits; counts mismatches and captures the first failing vector.
// Optional macro STOP_ON_FIRST_FAIL_EN ends the sweep at the first mismatch.
module equiv_sweep_checker
  import equiv_pkg::*;
#(
  parameter int unsigned N_IN   = 5,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [N_IN-1:0]  vec_out,
  input  logic [N_OUT-1:0] out_a,
  input  logic [N_OUT-1:0] out_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    mismatch_count,
  output logic             fail_valid,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             eq_live
);

  localparam int unsigned      CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]    RELOAD = CW'(SETTLE - 1);

  state_t          state, state_nx;
  logic            diff, last;
  logic            tmr_load, tmr_dec, tmr_zero;
  logic [N_IN:0]   count_nx;

  assign eq_live  = |(out_a ^ out_b);
  assign diff     = eq_live;
  assign last     = &vec_out;
  assign count_nx = mismatch_count + {{N_IN{1'b0}}, diff};

  settle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (RELOAD),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) state_nx = ST_SETTLE;
      ST_SETTLE:        if (tmr_zero) state_nx = ST_COMPARE;
      ST_COMPARE: begin
`ifdef STOP_ON_FIRST_FAIL_EN
        state_nx = (diff || last) ? ST_DONE : ST_SETTLE;
`else
        state_nx = last ? ST_DONE : ST_SETTLE;
`endif
      end
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_SETTLE) || (state == ST_COMPARE);
    done     = (state == ST_DONE);
    tmr_load = (start && ((state == ST_IDLE) || (state == ST_DONE))) ||
               ((state == ST_COMPARE) && (state_nx == ST_SETTLE));
    tmr_dec  = (state == ST_SETTLE) && !tmr_zero;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vec_out        <= '0;
      mismatch_count <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec_out        <= '0;
            mismatch_count <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
          end
        end
        ST_COMPARE: begin
          mismatch_count <= count_nx;
          if (diff && !fail_valid) begin
            fail_valid     <= 1'b1;
            first_fail_vec <= vec_out;
          end
          // vec_out only advances when another vector follows; on DONE it holds
          if (state_nx == ST_DONE) pass <= (count_nx == '0);
          else                     vec_out <= vec_out + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// Randomized self-checking bench for equiv_sweep_checker using a fault-mask reference model.
module tb_equiv_sweep_checker;

`ifdef STOP_ON_FIRST_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0, start2 = 1'b0;
  always #5 clk = ~clk;

  // dut1: N_IN=5, N_OUT=1, SETTLE=1
  logic [31:0] m1 = '0;
  logic [4:0]  vec1, ffv1;
  logic [0:0]  a1, b1;
  logic [5:0]  cnt1;
  logic        busy1, done1, pass1, fv1, eql1;
  assign a1 = ^vec1;
  assign b1 = a1 ^ m1[vec1];

  // dut2: N_IN=3, N_OUT=2, SETTLE=3
  logic [15:0] m2 = '0;
  logic [2:0]  vec2, ffv2;
  logic [1:0]  a2, b2;
  logic [3:0]  cnt2;
  logic        busy2, done2, pass2, fv2, eql2;
  assign a2 = {vec2[0], ^vec2};
  assign b2 = a2 ^ m2[{vec2, 1'b0} +: 2];

  equiv_sweep_checker #(.N_IN(5), .N_OUT(1), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .vec_out(vec1), .out_a(a1), .out_b(b1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_count(cnt1),
    .fail_valid(fv1), .first_fail_vec(ffv1), .eq_live(eql1));

  equiv_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .vec_out(vec2), .out_a(a2), .out_b(b2),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch_count(cnt2),
    .fail_valid(fv2), .first_fail_vec(ffv2), .eq_live(eql2));

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed values of the selected DUT
  logic [31:0] o_vec, o_cnt, o_ffv;
  logic        o_busy, o_done, o_pass, o_fv, o_eql;

  task automatic snap(input int d);
    if (d == 1) begin
      o_vec = 32'(vec1); o_cnt = 32'(cnt1); o_ffv = 32'(ffv1);
      o_busy = busy1; o_done = done1; o_pass = pass1; o_fv = fv1; o_eql = eql1;
    end else begin
      o_vec = 32'(vec2); o_cnt = 32'(cnt2); o_ffv = 32'(ffv2);
      o_busy = busy2; o_done = done2; o_pass = pass2; o_fv = fv2; o_eql = eql2;
    end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 1) start1 = v;
    else        start2 = v;
  endtask

  function automatic bit faulty(input int d, input int unsigned v);
    if (d == 1) return m1[v];
    return m2[2*v +: 2] != 2'b00;
  endfunction

  // Reference: sweep outcome from the fault set and the sweep timing rules
  int unsigned e_edge, e_cnt, e_first, e_vec;
  bit          e_fv, e_pass, e_eql;

  task automatic model(input int d);
    int unsigned nin, st, nv;
    int          f;
    nin = (d == 1) ? 5 : 3;
    st  = (d == 1) ? 1 : 3;
    nv  = 1 << nin;
    f   = -1;
    e_cnt = 0;
    for (int unsigned v = 0; v < nv; v++) begin
      if (faulty(d, v)) begin
        e_cnt++;
        if (f < 0) f = int'(v);
      end
    end
    e_fv    = (f >= 0);
    e_first = e_fv ? f : 0;
    if (STOP && e_fv) begin
      e_cnt  = 1;
      e_vec  = e_first;
      e_edge = 1 + (e_first + 1) * (st + 1);
    end else begin
      e_vec  = nv - 1;
      e_edge = 1 + nv * (st + 1);
    end
    e_pass = (e_cnt == 0);
    e_eql  = faulty(d, e_vec);
  endtask

  // Runs one sweep from a start pulse; the start-sampling edge is edge 1
  task automatic run(input int d, input string nm, input bit inject);
    int unsigned n, last, bad, st;
    logic [31:0] prev;
    st = (d == 1) ? 1 : 3;
    model(d);
    set_start(d, 1'b1);
    tick();
    set_start(d, 1'b0);
    n = 1;
    snap(d);
    check({nm, "_busy"}, 32'(o_busy), 1);
    check({nm, "_done_lo"}, 32'(o_done), 0);
    prev = o_vec; last = 1; bad = 0;
    while (!o_done && n < 400) begin
      if (inject && (n + 1 == 10 || n + 1 == 30)) set_start(d, 1'b1);
      tick();
      set_start(d, 1'b0);
      n++;
      snap(d);
      if (o_vec != prev) begin
        if ((n - last) != st + 1 || o_vec != prev + 1) bad++;
        last = n;
        prev = o_vec;
      end
    end
    check({nm, "_edge"}, n, e_edge);
    check({nm, "_done"}, 32'(o_done), 1);
    check({nm, "_busy_end"}, 32'(o_busy), 0);
    check({nm, "_count"}, o_cnt, e_cnt);
    check({nm, "_fvalid"}, 32'(o_fv), 32'(e_fv));
    check({nm, "_first"}, o_ffv, e_first);
    check({nm, "_pass"}, 32'(o_pass), 32'(e_pass));
    check({nm, "_vec"}, o_vec, e_vec);
    check({nm, "_eqlive"}, 32'(o_eql), 32'(e_eql));
    check({nm, "_hold"}, bad, 0);
    tick();
    snap(d);
    check({nm, "_done_held"}, 32'(o_done), 1);
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    snap(1);
    check("rst_vec", o_vec, 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_pass", 32'(o_pass), 0);
    check("rst_count", o_cnt, 0);
    check("rst_fvalid", 32'(o_fv), 0);
    check("rst_first", o_ffv, 0);

    m1 = '0;            run(1, "clean", 1'b0);
    m1 = 32'h0008_0000; run(1, "v19", 1'b0);
    m1 = '1;            run(1, "allbad", 1'b0);
    for (int i = 0; i < 4; i++) begin
      m1 = (i < 2) ? ($urandom & $urandom & $urandom) : $urandom;
      run(1, $sformatf("rnd%0d", i), 1'b0);
    end

    // Reset sampled at edge 20 mid-sweep
    m1 = $urandom;
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int i = 2; i < 20; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    snap(1);
    check("mid_rst_vec", o_vec, 0);
    check("mid_rst_busy", 32'(o_busy), 0);
    check("mid_rst_done", 32'(o_done), 0);
    check("mid_rst_pass", 32'(o_pass), 0);
    check("mid_rst_count", o_cnt, 0);
    check("mid_rst_fvalid", 32'(o_fv), 0);
    check("mid_rst_first", o_ffv, 0);
    m1 = '0;
    run(1, "after_rst", 1'b0);

    // Starts during the sweep are ignored; start while done restarts
    m1 = $urandom & $urandom;
    run(1, "inject", 1'b1);
    m1 = $urandom;
    run(1, "restart", 1'b0);

    m2 = 16'h1000 | 16'h0010;  // vectors 2 (bits 5:4) and 6 (bits 13:12)
    m2 = 16'h0010 | 16'h2000;
    run(2, "s3_pair", 1'b0);
    for (int i = 0; i < 3; i++) begin
      m2 = 16'($urandom & $urandom);
      run(2, $sformatf("s3_rnd%0d", i), 1'b0);
    end
    m2 = '0;
    run(2, "s3_clean", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/equiv_sweep_checker.md
Name: equiv_sweep_checker

Overview:
- Sequential successor to the combinational XOR equivalence top.
- Exhaustively drives every input vector of an N_IN-bit space into two externally instantiated circuits (original and candidate equivalent) and waits a settle interval after each vector.
- Compares the two N_OUT-bit outputs, counts mismatches and captures the first failing vector.
- Sits between the two circuit instances and the board status LEDs/testbench.

Parameters:
- N_IN, 5, number of circuit inputs; the sweep covers 0 .. 2^N_IN-1.
- N_OUT, 1, number of outputs per circuit; compared bitwise.
- SETTLE, 1, cycles to hold each vector before sampling; legal range >=1.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state on a rising clk edge.
- start  input  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- vec_out  output  N_IN  input vector driven to both circuits.
- out_a  input  N_OUT  output of original circuit.
- out_b  input  N_OUT  output of equivalent circuit.
- busy  output  1  high in SETTLE/COMPARE.
- done  output  1  high in DONE, held until the next start or reset.
- pass  output  1  valid when done=1; 1 iff mismatch_count==0.
- mismatch_count  output  N_IN+1  number of failing vectors; the width holds 2^N_IN without overflow.
- fail_valid  output  1  set when the first mismatch is captured.
- first_fail_vec  output  N_IN  vector of the first mismatch; 0 when fail_valid=0.
- eq_live  output  1  combinational: OR-reduce(out_a ^ out_b); 1 = differ now.

Behaviour:
- Reset values: state=IDLE, vec_out=0, busy=0, done=0, pass=0, mismatch_count=0, fail_valid=0, first_fail_vec=0, settle counter=0.
- States are IDLE, SETTLE, COMPARE, DONE.
- IDLE: when start=1, clear the count, fail_valid and first_fail_vec; set vec_out=0 and cnt=SETTLE-1; go to SETTLE.
- SETTLE: if cnt==0 go to COMPARE, else decrement cnt. Each vector is held exactly SETTLE cycles before COMPARE.
- COMPARE: diff = |(out_a ^ out_b) is sampled this cycle.
  - If diff: mismatch_count+1. If fail_valid==0, capture first_fail_vec=vec_out and set fail_valid=1.
  - If vec_out is all-ones: go to DONE and leave vec_out unchanged (no wrap).
  - Otherwise: vec_out+1, cnt=SETTLE-1, go to SETTLE.
- DONE: done=1, pass=(mismatch_count==0) registered on entry. start=1 restarts as from IDLE, clearing done on the next edge.
- start while busy is ignored and has no effect on the sweep.
- Latency: done rises exactly 1 + 2^N_IN*(SETTLE+1) edges after the edge that samples start. Defaults give 65.
- Reset mid-sweep: on the next edge all outputs return to reset values. No partial results are retained.
- Simultaneous start and reset: reset wins.
- eq_live is purely combinational and is not gated by state.

Optional Feature:
- Macro: STOP_ON_FIRST_FAIL_EN
- Defined: a COMPARE cycle with diff=1 goes directly to DONE after capturing first_fail_vec.
  - vec_out holds the failing vector.
  - mismatch_count=1 and pass=0.
  - Passing sweeps behave as in the undefined case.
- Undefined: the full sweep always runs, and mismatch_count reports the total number of failing vectors.

Decomposition:
- Shared package equiv_pkg: state enum (IDLE, SETTLE, COMPARE, DONE) and a localparam for the state width.
- The counter width, $clog2(SETTLE) with a minimum of 1, is computed locally.
- One natural sub-module, settle_timer: a load/decrement counter with a zero flag, reusable by later checker blocks.
- Everything else stays in equiv_sweep_checker.

Test Plan:
- Bench models out_a=out_b=^vec, N_IN=5, SETTLE=1, start pulse -> done at edge 65, pass=1, mismatch_count=0, fail_valid=0, vec_out=5'h1F.
- out_b=out_a^(vec_out==19) -> mismatch_count=1, first_fail_vec=19, fail_valid=1, pass=0.
- out_b=~out_a -> mismatch_count=32, first_fail_vec=0. With STOP_ON_FIRST_FAIL_EN defined: done at edge 3, vec_out=0, count=1.
- Assert reset at edge 20 mid-sweep -> all outputs return to reset values next edge. A start afterwards completes normally in 65 cycles.
- Pulse start at edges 10 and 30 during a sweep -> ignored, and done still arrives at edge 65. Start while done=1 -> done drops and a new sweep runs.
- N_IN=3, SETTLE=3, out_b differs at vectors 2 and 6 -> done at edge 33, mismatch_count=2, first_fail_vec=2. vec_out changes only every 4 cycles.
